// File: rtl/mem_word_ctrl.sv
// Word-access front end for a byte-wide RAM with one cycle of read latency.
// Each 16-bit request becomes two byte accesses, at A and then at A+1.
module mem_word_ctrl #(
    parameter int unsigned MEM_LENGTH = 255,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic [15:0] mem_read_address,
    output logic [15:0] mem_write_address,
    output logic [7:0]  mem_data_in,
    output logic        mem_write_enable,
    input  logic [7:0]  mem_data_out
);

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 16;
    localparam int unsigned BW = 8;
    localparam int unsigned LAST_WORD_ADDR = MEM_LENGTH - 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD0  = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        WR0  = 3'd4,
        WR1  = 3'd5,
        RESP = 3'd6
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic [AW-1:0] addr_q;
    logic [AW-1:0] addr_nxt;
    logic [BW-1:0] hold_q;
    logic [BW-1:0] hold_nxt;

    logic          resp_valid_nxt;
    logic [DW-1:0] resp_rdata_nxt;
    logic          resp_err_nxt;
    logic [AW-1:0] mem_read_address_nxt;
    logic [AW-1:0] mem_write_address_nxt;
    logic [BW-1:0] mem_data_in_nxt;
    logic          mem_write_enable_nxt;

    logic          range_err_c;
    logic [AW-1:0] addr_p1_c;
    logic [BW-1:0] wbyte_a_c;
    logic [BW-1:0] wbyte_a1_c;

    assign req_ready   = (state == IDLE);
    // A+1 must exist in the RAM; the all-ones address would also wrap to 0
    assign range_err_c = (32'(req_addr) > LAST_WORD_ADDR) || (req_addr == '1);
    assign addr_p1_c   = addr_q + AW'(1);
    assign wbyte_a_c   = BIG_ENDIAN ? req_wdata[15:8] : req_wdata[7:0];
    assign wbyte_a1_c  = BIG_ENDIAN ? req_wdata[7:0]  : req_wdata[15:8];

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            addr_q            <= '0;
            hold_q            <= '0;
            resp_valid        <= 1'b0;
            resp_rdata        <= '0;
            resp_err          <= 1'b0;
            mem_read_address  <= '0;
            mem_write_address <= '0;
            mem_data_in       <= '0;
            mem_write_enable  <= 1'b0;
        end else begin
            state             <= state_nxt;
            addr_q            <= addr_nxt;
            hold_q            <= hold_nxt;
            resp_valid        <= resp_valid_nxt;
            resp_rdata        <= resp_rdata_nxt;
            resp_err          <= resp_err_nxt;
            mem_read_address  <= mem_read_address_nxt;
            mem_write_address <= mem_write_address_nxt;
            mem_data_in       <= mem_data_in_nxt;
            mem_write_enable  <= mem_write_enable_nxt;
        end
    end

    // Next state
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (range_err_c)    state_nxt = RESP;
                    else if (req_write) state_nxt = WR0;
                    else                state_nxt = RD0;
                end
            end
            RD0:     state_nxt = RD1;
            RD1:     state_nxt = RD2;
            RD2:     state_nxt = RESP;
            WR0:     state_nxt = WR1;
            WR1:     state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs; hold_q carries the second write
    // byte on writes and the byte read from A on reads
    always_comb begin
        addr_nxt              = addr_q;
        hold_nxt              = hold_q;
        resp_valid_nxt        = resp_valid;
        resp_rdata_nxt        = resp_rdata;
        resp_err_nxt          = resp_err;
        mem_read_address_nxt  = mem_read_address;
        mem_write_address_nxt = mem_write_address;
        mem_data_in_nxt       = mem_data_in;
        mem_write_enable_nxt  = mem_write_enable;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    addr_nxt = req_addr;
                    if (range_err_c) begin
                        resp_valid_nxt = 1'b1;
                        resp_err_nxt   = 1'b1;
                        resp_rdata_nxt = '0;
                    end else if (req_write) begin
                        mem_write_address_nxt = req_addr;
                        mem_data_in_nxt       = wbyte_a_c;
                        mem_write_enable_nxt  = 1'b1;
                        hold_nxt              = wbyte_a1_c;
                    end else begin
                        mem_read_address_nxt = req_addr;
                    end
                end
            end
            RD0: mem_read_address_nxt = addr_p1_c;
            RD1: hold_nxt = mem_data_out;
            RD2: begin
                resp_rdata_nxt = BIG_ENDIAN ? {hold_q, mem_data_out} : {mem_data_out, hold_q};
                resp_valid_nxt = 1'b1;
                resp_err_nxt   = 1'b0;
            end
            WR0: begin
                mem_write_address_nxt = addr_p1_c;
                mem_data_in_nxt       = hold_q;
            end
            WR1: begin
                mem_write_enable_nxt = 1'b0;
                resp_valid_nxt       = 1'b1;
                resp_err_nxt         = 1'b0;
            end
            RESP: if (resp_ready) resp_valid_nxt = 1'b0;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_word_ctrl.sv
// Bench for mem_word_ctrl: little- and big-endian instances run in lockstep,
// each on its own byte RAM, checked against a word-level reference model.
module tb_mem_word_ctrl;

    localparam int unsigned MEM_LEN = 255;
    localparam int          TIMEOUT = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        resp_ready;

    logic        obs_ready [2];
    logic        obs_rv    [2];
    logic        obs_err   [2];
    logic [15:0] obs_rdata [2];
    logic [15:0] obs_ra    [2];
    logic [15:0] obs_wa    [2];
    logic [7:0]  obs_din   [2];
    logic        obs_we    [2];

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]  mdl_mem   [2][256];
    logic [15:0] mdl_rdata [2];

    always #5 clk = ~clk;

    function automatic logic [7:0] init_byte(input int i);
        if (i == 16) return 8'h34;
        if (i == 17) return 8'h12;
        return 8'(i * 37 + 5);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [7:0] ram [65536];
        logic [7:0] dout;

        initial for (int i = 0; i < 65536; i++) ram[i] = init_byte(i);

        always @(posedge clk) begin
            if (obs_we[g]) ram[obs_wa[g]] <= obs_din[g];
            dout <= ram[obs_ra[g]];
        end

        mem_word_ctrl #(.MEM_LENGTH(MEM_LEN), .BIG_ENDIAN(g == 1)) u_dut (
            .clk               (clk),
            .rst               (rst),
            .req_valid         (req_valid),
            .req_ready         (obs_ready[g]),
            .req_write         (req_write),
            .req_addr          (req_addr),
            .req_wdata         (req_wdata),
            .resp_valid        (obs_rv[g]),
            .resp_ready        (resp_ready),
            .resp_rdata        (obs_rdata[g]),
            .resp_err          (obs_err[g]),
            .mem_read_address  (obs_ra[g]),
            .mem_write_address (obs_wa[g]),
            .mem_data_in       (obs_din[g]),
            .mem_write_enable  (obs_we[g]),
            .mem_data_out      (dout)
        );
    end

    function automatic logic [7:0] ram_byte(input int e, input int a);
        return (e == 0) ? g_dut[0].ram[a] : g_dut[1].ram[a];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_ram(input int a);
        for (int e = 0; e < 2; e++)
            check_eq($sformatf("ram[%0d] e%0d", a, e), 32'(ram_byte(e, a)), 32'(mdl_mem[e][a]));
    endtask

    // One request from a falling edge with the controller idle; returns at the
    // falling edge after the response handshake. Optionally holds the next
    // request on the bus while the response is stalled.
    task automatic run_txn(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                           input int stall, input bit hold_next,
                           input logic nwr, input logic [15:0] na, input logic [15:0] nwd);
        bit          err;
        int          ai;
        int          exp_lat;
        int          lat;
        int          we_cnt [2];
        logic [15:0] exp_rd [2];
        ai      = int'(a);
        err     = (ai + 1) > (int'(MEM_LEN) - 1);
        exp_lat = err ? 1 : (wr ? 3 : 4);
        for (int e = 0; e < 2; e++) begin
            if (err) begin
                exp_rd[e] = 16'h0000;
            end else if (wr) begin
                mdl_mem[e][ai]     = (e == 1) ? wd[15:8] : wd[7:0];
                mdl_mem[e][ai + 1] = (e == 1) ? wd[7:0]  : wd[15:8];
                exp_rd[e]          = mdl_rdata[e];
            end else begin
                exp_rd[e] = (e == 1) ? {mdl_mem[e][ai], mdl_mem[e][ai + 1]}
                                     : {mdl_mem[e][ai + 1], mdl_mem[e][ai]};
            end
            mdl_rdata[e] = exp_rd[e];
            we_cnt[e]    = 0;
            check_eq($sformatf("req_ready e%0d", e), 32'(obs_ready[e]), 32'd1);
        end
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = wd;
        @(negedge clk);
        if (hold_next) begin
            req_write = nwr;
            req_addr  = na;
            req_wdata = nwd;
        end else begin
            req_valid = 1'b0;
        end
        lat = 1;
        while (!obs_rv[0] && lat < TIMEOUT) begin
            for (int e = 0; e < 2; e++) we_cnt[e] += int'(obs_we[e]);
            @(negedge clk);
            lat++;
        end
        check_eq($sformatf("latency a=%h wr=%0d", a, wr), 32'(lat), 32'(exp_lat));
        for (int e = 0; e < 2; e++) begin
            check_eq($sformatf("resp_valid e%0d", e), 32'(obs_rv[e]), 32'd1);
            check_eq($sformatf("resp_err e%0d a=%h", e, a), 32'(obs_err[e]), 32'(err));
            check_eq($sformatf("resp_rdata e%0d a=%h", e, a), 32'(obs_rdata[e]), 32'(exp_rd[e]));
            check_eq($sformatf("we_pulse e%0d a=%h", e, a), 32'(we_cnt[e]), (wr && !err) ? 32'd2 : 32'd0);
            check_eq($sformatf("we_low e%0d", e), 32'(obs_we[e]), 32'd0);
        end
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            for (int e = 0; e < 2; e++) begin
                check_eq($sformatf("stall_valid e%0d", e), 32'(obs_rv[e]), 32'd1);
                check_eq($sformatf("stall_rdata e%0d", e), 32'(obs_rdata[e]), 32'(exp_rd[e]));
                check_eq($sformatf("stall_err e%0d", e), 32'(obs_err[e]), 32'(err));
                check_eq($sformatf("stall_ready e%0d", e), 32'(obs_ready[e]), 32'd0);
                check_eq($sformatf("stall_we e%0d", e), 32'(obs_we[e]), 32'd0);
            end
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        for (int e = 0; e < 2; e++) begin
            check_eq($sformatf("post_hs_valid e%0d", e), 32'(obs_rv[e]), 32'd0);
            check_eq($sformatf("post_hs_ready e%0d", e), 32'(obs_ready[e]), 32'd1);
        end
    endtask

    // Reset arrives after the first byte of a write pair has reached the RAM
    task automatic reset_mid_write(input logic [15:0] a, input logic [15:0] wd);
        int ai;
        ai        = int'(a);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = a;
        req_wdata = wd;
        @(negedge clk);
        req_valid = 1'b0;
        for (int e = 0; e < 2; e++)
            check_eq($sformatf("rmw_we_before e%0d", e), 32'(obs_we[e]), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        for (int e = 0; e < 2; e++) begin
            mdl_mem[e][ai] = (e == 1) ? wd[15:8] : wd[7:0];
            mdl_rdata[e]   = 16'h0000;
            check_eq($sformatf("rmw_we e%0d", e), 32'(obs_we[e]), 32'd0);
            check_eq($sformatf("rmw_valid e%0d", e), 32'(obs_rv[e]), 32'd0);
            check_eq($sformatf("rmw_ready e%0d", e), 32'(obs_ready[e]), 32'd1);
            check_eq($sformatf("rmw_waddr e%0d", e), 32'(obs_wa[e]), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_ram(ai);
        check_ram(ai + 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra;
        int          sel;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;
        for (int e = 0; e < 2; e++) begin
            for (int i = 0; i < 256; i++) mdl_mem[e][i] = init_byte(i);
            mdl_rdata[e] = 16'h0000;
        end
        repeat (2) @(negedge clk);
        for (int e = 0; e < 2; e++) begin
            check_eq($sformatf("rst_valid e%0d", e), 32'(obs_rv[e]), 32'd0);
            check_eq($sformatf("rst_err e%0d", e), 32'(obs_err[e]), 32'd0);
            check_eq($sformatf("rst_rdata e%0d", e), 32'(obs_rdata[e]), 32'd0);
            check_eq($sformatf("rst_we e%0d", e), 32'(obs_we[e]), 32'd0);
            check_eq($sformatf("rst_raddr e%0d", e), 32'(obs_ra[e]), 32'd0);
            check_eq($sformatf("rst_waddr e%0d", e), 32'(obs_wa[e]), 32'd0);
            check_eq($sformatf("rst_din e%0d", e), 32'(obs_din[e]), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        run_txn(1'b0, 16'h0010, 16'h0000, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        check_eq("read_0x10 le", 32'(obs_rdata[0]), 32'h1234);
        run_txn(1'b1, 16'h0020, 16'hBEEF, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        check_eq("ram_0x20 le", 32'(ram_byte(0, 32)), 32'hEF);
        check_eq("ram_0x20 be", 32'(ram_byte(1, 32)), 32'hBE);
        check_ram(32);
        check_ram(33);
        run_txn(1'b0, 16'h0020, 16'h0000, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        check_eq("readback le", 32'(obs_rdata[0]), 32'hBEEF);
        check_eq("readback be", 32'(obs_rdata[1]), 32'hBEEF);

        run_txn(1'b0, 16'd253,   16'h0000, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_txn(1'b0, 16'd254,   16'h0000, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_txn(1'b1, 16'd254,   16'hA1B2, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_txn(1'b0, 16'hFFFF,  16'h0000, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        run_txn(1'b1, 16'hFFFF,  16'hC3D4, 0, 1'b0, 1'b0, 16'h0, 16'h0);
        check_ram(253);
        check_ram(254);

        run_txn(1'b0, 16'h0030, 16'h0000, 5, 1'b1, 1'b1, 16'h0040, 16'h1357);
        run_txn(1'b1, 16'h0040, 16'h1357, 0, 1'b0, 1'b0, 16'h0, 16'h0);

        reset_mid_write(16'h0050, 16'hA55A);

        run_txn(1'b0, 16'h0050, 16'h0000, 0, 1'b1, 1'b1, 16'h0060, 16'h2468);
        run_txn(1'b1, 16'h0060, 16'h2468, 0, 1'b1, 1'b0, 16'h0060, 16'h0000);
        run_txn(1'b0, 16'h0060, 16'h0000, 0, 1'b1, 1'b1, 16'h0011, 16'h9ABC);
        run_txn(1'b1, 16'h0011, 16'h9ABC, 0, 1'b0, 1'b0, 16'h0, 16'h0);

        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            case (sel)
                0:       ra = 16'd254;
                1:       ra = 16'hFFFF;
                2:       ra = 16'd253;
                3:       ra = 16'($urandom_range(255, 65535));
                default: ra = 16'($urandom_range(0, 253));
            endcase
            run_txn(1'($urandom_range(0, 1)), ra, 16'($urandom), int'($urandom_range(0, 2)),
                    1'b0, 1'b0, 16'h0, 16'h0);
        end

        for (int i = 0; i < 256; i++) check_ram(i);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
